// File: rtl/dest_select_stage.sv
// dest_select_stage: registered write-back destination select with a small skid FIFO
// and hazard match of two source indices against pending destinations.
module dest_select_stage #(
    parameter int WIDTH      = 17,
    parameter int LINK_VALUE = 10,
    parameter int DEPTH      = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Input,
    input  logic [WIDTH-1:0] Alt_Input,
    input  logic [1:0]       Selection,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Output,
    output logic [1:0]       Out_Sel,
    input  logic [WIDTH-1:0] Src_A,
    input  logic [WIDTH-1:0] Src_B,
    output logic             Hit_A,
    output logic             Hit_B
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [1:0]       sel_q  [DEPTH];
    logic [1:0]       sel_d  [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [WIDTH-1:0] sel_val;
    logic             push, pop, valid_i;

    always_comb begin
        sel_val = (Selection == 2'd0) ? Input :
                  (Selection == 2'd1) ? '0 :
                  (Selection == 2'd2) ? WIDTH'(LINK_VALUE) : Alt_Input;
        In_Ready  = (cnt_q != FULL);
        Out_Valid = (cnt_q != '0);
        Output    = Out_Valid ? data_q[rd_q] : '0;
        Out_Sel   = Out_Valid ? sel_q[rd_q] : 2'd0;
        push      = In_Valid && In_Ready && !Flush;
        pop       = Out_Valid && Out_Ready && !Flush;
        data_d    = data_q;
        sel_d     = sel_q;
        if (push) begin
            data_d[wr_q] = sel_val;
            sel_d[wr_q]  = Selection;
        end
        wr_d  = Flush ? '0 : !push ? wr_q : (wr_q == LAST) ? '0 : wr_q + 1'b1;
        rd_d  = Flush ? '0 : !pop ? rd_q : (rd_q == LAST) ? '0 : rd_q + 1'b1;
        cnt_d = Flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        // An entry is live when its distance from the read pointer is below the count.
        Hit_A = 1'b0;
        Hit_B = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_i = ((i - int'(rd_q) + DEPTH) % DEPTH) < int'(cnt_q);
            Hit_A = Hit_A | (valid_i && data_q[i] == Src_A && data_q[i] != '0);
            Hit_B = Hit_B | (valid_i && data_q[i] == Src_B && data_q[i] != '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                sel_q[i]  <= 2'd0;
            end
        end else begin
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end
endmodule

// File: doc/dest_select_stage.md
Name: dest_select_stage

Overview:
- Parametrised, registered successor to the write-back destination-select mux.
- Picks the destination index (field, zero, link constant or alternate field) and holds it in a 2-entry skid buffer with valid/ready handshake and flush.
- Reports whether each of two source indices matches any pending destination, for the hazard unit.
- Sits between decode and the register-file write-port stage.

Parameters:
- WIDTH, 17, width of destination index / data path.
- LINK_VALUE, 10, constant emitted for Selection=2 (link destination).
- DEPTH, 2, skid buffer entries; legal values 1..4. Count register is clog2(DEPTH+1) bits.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- In_Valid  input  1  upstream has a destination to enqueue.
- In_Ready  output  1  stage can accept this cycle.
- Input  input  WIDTH  primary destination field.
- Alt_Input  input  WIDTH  alternate destination field.
- Selection  input  2  0=Input, 1=zero, 2=LINK_VALUE, 3=Alt_Input.
- Flush  input  1  discard all pending entries.
- Out_Valid  output  1  head entry valid.
- Out_Ready  input  1  downstream consumes head.
- Output  output  WIDTH  head destination.
- Out_Sel  output  2  Selection code stored with head entry.
- Src_A  input  WIDTH  source index A for hazard compare.
- Src_B  input  WIDTH  source index B for hazard compare.
- Hit_A  output  1  Src_A matches a pending nonzero destination.
- Hit_B  output  1  Src_B matches a pending nonzero destination.

Behaviour:
- Reset (Reset_n=0 at posedge): count=0, read/write pointers=0, all entries invalid. Out_Valid=0, Output=0, Out_Sel=0, Hit_A=Hit_B=0, In_Ready=1 from the first cycle after reset. Reset applied mid-transfer drops all entries with no partial output.
- Mux: selected value = Input / 0 / LINK_VALUE (zero-extended or truncated to WIDTH) / Alt_Input for Selection 0/1/2/3. The mux is fully specified, with no latch for any code. Selected value and Selection are stored together.
- Push when In_Valid && In_Ready. Pop when Out_Valid && Out_Ready.
- In_Ready = (count != DEPTH), combinational from registered count only. It has no dependence on Out_Ready, so there is no ready loop.
- Out_Valid = (count != 0). Output/Out_Sel = head entry when Out_Valid, else 0.
- Latency: an entry pushed at edge N appears on Output after edge N when the buffer was empty (1 cycle).
- Simultaneous push and pop:
  - count=0: not possible, since pop requires valid.
  - 0<count<DEPTH: count unchanged, FIFO order preserved.
  - count=DEPTH: only the pop occurs (In_Ready=0); next cycle In_Ready=1.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Flush (sampled at posedge, Reset_n=1): count and pointers go to 0. A push or pop in the same cycle is ignored. Out_Valid=0 and Out_Ready is don't-care the next cycle. Reset has priority over Flush.
- Hazard compare (combinational over registered entries):
  - Hit_A = OR over valid entries of (entry == Src_A && entry != 0). Same for Hit_B.
  - Entries that are popping or pushing this cycle are not considered; only current contents count.
  - Hits are 0 when empty and 0 for Src=0.
- Out_Valid stays high and the head is stable while Out_Ready=0. The head changes only after a pop.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with In_Valid=1, Input=5 -> after release Out_Valid=0, Output=0, In_Ready=1, Hit_A=Hit_B=0.
- Mux codes: push Sel=0/Input=7, Sel=1, Sel=2, Sel=3/Alt=9 with Out_Ready=1 -> Output sequence 7, 0, 10, 9 each one cycle after push; Out_Sel 0, 1, 2, 3.
- Full/backpressure: Out_Ready=0, push 3, 4 -> In_Ready=0 after second push. A third push (6) is not accepted. Raise Out_Ready -> Output 3 then 4, In_Ready=1 after first pop, 6 accepted then.
- Simultaneous push/pop at count=1: head 3, push 4 while popping -> next Output=4, count stays 1.
- Hazard: buffer holds {3, 0(Sel=1)}; Src_A=3, Src_B=0 -> Hit_A=1, Hit_B=0. Pop 3 -> Hit_A=0 the next cycle.
- Flush: buffer full {3, 4}; assert Flush with In_Valid=1, Input=8 -> next cycle Out_Valid=0, Hit_A=0 for Src_A=3/4/8, In_Ready=1. A later push of 8 appears alone.
